// File: rtl/inst_fifo.sv
// Instruction fetch-to-decode queue: multi-word push, multi-word pop, first-word-fall-through.
// Storage is a circular buffer with wrapping pointers and an explicit occupancy counter.
module inst_fifo #(
    parameter int DEPTH       = 16,
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             push_valid,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0] push_count,
    input  logic [31:0]                      push_pc,
    input  logic [32*FETCH_WIDTH-1:0]        push_inst,
    input  logic                             push_err,
    output logic                             push_ready,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0] pop_count,
    output logic [ISSUE_WIDTH-1:0]           out_valid,
    output logic [32*ISSUE_WIDTH-1:0]        out_inst,
    output logic [32*ISSUE_WIDTH-1:0]        out_pc,
    output logic [ISSUE_WIDTH-1:0]           out_err,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          overflow_reg;

    logic [31:0] mem_inst [DEPTH];
    logic [31:0] mem_pc   [DEPTH];
    logic        mem_err  [DEPTH];

    logic [CW-1:0] free_cnt;
    logic [CW-1:0] push_n;
    logic [CW-1:0] pop_n;
    logic          push_fire;

    // Ready depends only on current occupancy so a full group always fits regardless of pops.
    always_comb begin
        free_cnt   = CW'(DEPTH) - count_reg;
        push_ready = free_cnt >= CW'(FETCH_WIDTH);
        push_fire  = push_valid && push_ready && !flush;
        push_n     = '0;
        if (push_fire) begin
            push_n = (CW'(push_count) > CW'(FETCH_WIDTH)) ? CW'(FETCH_WIDTH) : CW'(push_count);
        end
        pop_n      = (CW'(pop_count) > count_reg) ? count_reg : CW'(pop_count);
        count_next = count_reg + push_n - pop_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PW'(push_n);
            rd_ptr_reg <= rd_ptr_reg + PW'(pop_n);
            count_reg  <= count_next;
            if (push_valid && !push_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_fire) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (CW'(k) < push_n) begin
                    mem_inst[wr_ptr_reg + PW'(k)] <= push_inst[32*k +: 32];
                    mem_pc[wr_ptr_reg + PW'(k)]   <= push_pc + 32'(4 * k);
                    mem_err[wr_ptr_reg + PW'(k)]  <= push_err;
                end
            end
        end
    end

    // Slot i reads the i-th oldest entry; empty slots are forced to zero.
    genvar gi;
    generate
        for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
            logic [PW-1:0] addr;
            logic          slot_valid;
            assign addr                  = rd_ptr_reg + PW'(gi);
            assign slot_valid            = count_reg > CW'(gi);
            assign out_valid[gi]         = slot_valid;
            assign out_inst[32*gi +: 32] = slot_valid ? mem_inst[addr] : 32'h0;
            assign out_pc[32*gi +: 32]   = slot_valid ? mem_pc[addr] : 32'h0;
            assign out_err[gi]           = slot_valid ? mem_err[addr] : 1'b0;
        end
    endgenerate

    assign count    = count_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_inst_fifo.sv
// Scoreboard bench for inst_fifo (DEPTH=16, FETCH_WIDTH=2, ISSUE_WIDTH=2).
module tb_inst_fifo;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        push_valid;
    logic [1:0]  push_count;
    logic [31:0] push_pc;
    logic [63:0] push_inst;
    logic        push_err;
    logic        push_ready;
    logic [1:0]  pop_count;
    logic [1:0]  out_valid;
    logic [63:0] out_inst;
    logic [63:0] out_pc;
    logic [1:0]  out_err;
    logic [4:0]  count;
    logic        overflow;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } entry_t;

    entry_t q[$];
    bit     ovf_m;
    int     asserts;
    int     fails;

    inst_fifo #(.DEPTH(16), .FETCH_WIDTH(2), .ISSUE_WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push_valid(push_valid),
        .push_count(push_count),
        .push_pc   (push_pc),
        .push_inst (push_inst),
        .push_err  (push_err),
        .push_ready(push_ready),
        .pop_count (pop_count),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_err   (out_err),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus and update the reference queue at the edge.
    task automatic step(input bit pv, input int pcnt, input logic [31:0] pc,
                        input logic [31:0] i0, input logic [31:0] i1,
                        input bit err, input int pop, input bit fl);
        bit     ready;
        int     n;
        entry_t e;
        push_valid = pv;
        push_count = 2'(pcnt);
        push_pc    = pc;
        push_inst  = {i1, i0};
        push_err   = err;
        pop_count  = 2'(pop);
        flush      = fl;
        ready      = (16 - q.size()) >= 2;
        @(posedge clk);
        if (fl) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            n = (pop < q.size()) ? pop : q.size();
            repeat (n) void'(q.pop_front());
            if (pv && ready) begin
                for (int k = 0; k < pcnt; k++) begin
                    e.inst = (k == 0) ? i0 : i1;
                    e.pc   = pc + 32'(4 * k);
                    e.err  = err;
                    q.push_back(e);
                end
            end
            if (pv && !ready) ovf_m = 1'b1;
        end
        #1;
        $display("t=%0t push=%0b/%0d pc=%h pop=%0d flush=%0b -> count=%0d", $time, pv, pcnt, pc, pop, fl, count);
        push_valid = 1'b0;
        pop_count  = 2'd0;
        flush      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; push_valid = 1'b0; push_count = 2'd0;
        push_pc = 32'h0; push_inst = 64'h0; push_err = 1'b0; pop_count = 2'd0;
        #12;
        asserts++;
        if (out_valid !== 2'b00 || count !== 5'd0 || push_ready !== 1'b1 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: valid=%b count=%0d ready=%b ovf=%b, expected 00/0/1/0", out_valid, count, push_ready, overflow);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        step(1, 2, 32'hBFC00000, 32'h24010001, 32'h24020002, 0, 0, 0);
        asserts++;
        if (out_valid !== 2'b11 || out_pc !== {32'hBFC00004, 32'hBFC00000} || count !== 5'd2
            || out_inst !== {32'h24020002, 32'h24010001}) begin
            fails++;
            $display("FAIL basic_push: valid=%b pc=%h inst=%h count=%0d, expected 11 bfc00004bfc00000 2402000224010001 2", out_valid, out_pc, out_inst, count);
        end
        step(0, 0, 0, 0, 0, 0, 2, 0);
        asserts++;
        if (out_valid !== 2'b00 || out_inst !== 64'h0 || out_pc !== 64'h0 || count !== 5'(q.size())) begin
            fails++;
            $display("FAIL basic_drain: valid=%b inst=%h pc=%h count=%0d, expected 00 0 0 %0d", out_valid, out_inst, out_pc, count, q.size());
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 7; i++) step(1, 2, 32'h1000 + 32'(8 * i), 32'hA000 + 32'(i), 32'hB000 + 32'(i), 0, 0, 0);
        step(1, 1, 32'h1038, 32'hC000, 32'h0, 0, 0, 0);
        asserts++;
        if (count !== 5'd15 || push_ready !== ((16 - q.size()) >= 2)) begin
            fails++;
            $display("FAIL fill_15: count=%0d ready=%b, expected 15 0", count, push_ready);
        end
        step(1, 2, 32'h2000, 32'hDEAD, 32'hBEEF, 0, 0, 0);
        asserts++;
        if (count !== 5'(q.size()) || overflow !== ovf_m || q.size() != 15) begin
            fails++;
            $display("FAIL overflow_drop: count=%0d ovf=%b, expected 15 1", count, overflow);
        end
        asserts++;
        if (out_pc !== {q[1].pc, q[0].pc} || out_inst !== {q[1].inst, q[0].inst}) begin
            fails++;
            $display("FAIL overflow_head: pc=%h inst=%h, expected %h%h %h%h", out_pc, out_inst, q[1].pc, q[0].pc, q[1].inst, q[0].inst);
        end
        step(1, 2, 32'h3000, 32'h1, 32'h2, 0, 1, 1);
        asserts++;
        if (count !== 5'd0 || overflow !== 1'b0 || out_valid !== 2'b00 || push_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush: count=%0d ovf=%b valid=%b ready=%b, expected 0 0 00 1", count, overflow, out_valid, push_ready);
        end
    endtask

    task automatic test_pop_clamp();
        step(1, 1, 32'h4000, 32'h11111111, 32'h0, 0, 0, 0);
        step(1, 2, 32'h5000, 32'h22222222, 32'h33333333, 0, 2, 0);
        asserts++;
        if (count !== 5'd2 || q.size() != 2 || out_inst[31:0] !== 32'h22222222 || out_pc[31:0] !== 32'h5000) begin
            fails++;
            $display("FAIL pop_clamp: count=%0d slot0 inst=%h pc=%h, expected 2 22222222 00005000", count, out_inst[31:0], out_pc[31:0]);
        end
        for (int i = 0; i < 2; i++) begin
            asserts++;
            if (out_valid[i] !== 1'b1 || out_inst[32*i +: 32] !== q[i].inst || out_pc[32*i +: 32] !== q[i].pc || out_err[i] !== q[i].err) begin
                fails++;
                $display("FAIL clamp_slot%0d: v=%b inst=%h pc=%h err=%b, expected 1 %h %h %b", i, out_valid[i], out_inst[32*i +: 32], out_pc[32*i +: 32], out_err[i], q[i].inst, q[i].pc, q[i].err);
            end
        end
        step(0, 0, 0, 0, 0, 0, 3, 0);
        asserts++;
        if (count !== 5'd0 || out_valid !== 2'b00) begin
            fails++;
            $display("FAIL overpop: count=%0d valid=%b, expected 0 00", count, out_valid);
        end
    endtask

    task automatic test_wrap();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(1, 2, 32'h8000 + 32'(8 * i), 32'h100 + 32'(i), 32'h200 + 32'(i), 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 2, 0);
        step(1, 1, 32'h9000, 32'h300, 32'h0, 0, 0, 0);
        step(1, 2, 32'hA000, 32'hE0E0E0E0, 32'hE1E1E1E1, 1, 0, 0);
        asserts++;
        if (count !== 5'd15 || q.size() != 15) begin
            fails++;
            $display("FAIL wrap_fill: count=%0d, expected 15", count);
        end
        repeat (6) step(0, 0, 0, 0, 0, 0, 2, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        asserts++;
        if (out_err !== 2'b11 || out_pc !== {32'hA004, 32'hA000} || out_inst !== {32'hE1E1E1E1, 32'hE0E0E0E0}) begin
            fails++;
            $display("FAIL wrap_order: err=%b pc=%h inst=%h, expected 11 0000a0040000a000 e1e1e1e1e0e0e0e0", out_err, out_pc, out_inst);
        end
        for (int i = 0; i < 2; i++) begin
            asserts++;
            if (out_pc[32*i +: 32] !== q[i].pc || out_err[i] !== q[i].err) begin
                fails++;
                $display("FAIL wrap_slot%0d: pc=%h err=%b, expected %h %b", i, out_pc[32*i +: 32], out_err[i], q[i].pc, q[i].err);
            end
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 2, 32'hC000 + 32'(8 * i), 32'h7000 + 32'(i), 32'h7100 + 32'(i), 0, 0, 0);
        step(1, 1, 32'hC018, 32'h7200, 32'h0, 0, 0, 0);
        asserts++;
        if (count !== 5'd7) begin
            fails++;
            $display("FAIL pre_reset_count: count=%0d, expected 7", count);
        end
        #2;
        rst = 1'b0;
        #1;
        asserts++;
        if (out_valid !== 2'b00 || out_inst !== 64'h0 || out_pc !== 64'h0 || out_err !== 2'b00
            || count !== 5'd0 || push_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: valid=%b inst=%h pc=%h err=%b count=%0d ready=%b, expected all zero ready=1", out_valid, out_inst, out_pc, out_err, count, push_ready);
        end
        push_valid = 1'b1; push_count = 2'd2; push_pc = 32'hD000; push_inst = 64'h5;
        @(posedge clk); #2;
        push_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        ovf_m = 1'b0;
        @(posedge clk); #1;
        asserts++;
        if (count !== 5'd0 || push_ready !== 1'b1 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: count=%0d ready=%b ovf=%b, expected 0 1 0", count, push_ready, overflow);
        end
    endtask

    task automatic test_stream();
        logic [31:0] last_pc;
        last_pc = 32'h0;
        for (int c = 0; c < 100; c++) begin
            if (c % 2 == 0) begin
                step(1, 1, 32'hE000 + 32'(4 * c), 32'hF000 + 32'(c), 32'h0, 0, 0, 0);
                asserts++;
                if (out_valid[0] !== 1'b1 || out_pc[31:0] <= last_pc || out_pc[31:0] !== q[0].pc || out_inst[31:0] !== q[0].inst) begin
                    fails++;
                    $display("FAIL stream_pc c=%0d: v=%b pc=%h inst=%h, expected pc %h inst %h above %h", c, out_valid[0], out_pc[31:0], out_inst[31:0], q[0].pc, q[0].inst, last_pc);
                end
                last_pc = out_pc[31:0];
            end else begin
                step(0, 0, 0, 0, 0, 0, 1, 0);
            end
            asserts++;
            if (count > 5'd1 || count !== 5'(q.size())) begin
                fails++;
                $display("FAIL stream_count c=%0d: count=%0d, expected %0d (max 1)", c, count, q.size());
            end
        end
    endtask

    initial begin
        asserts = 0;
        fails   = 0;
        ovf_m   = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_pop_clamp();
        test_wrap();
        test_async_reset();
        test_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
